// File: rtl/maxmin_stream.sv
// Streaming frame max/min finder: collects COUNT samples, then publishes
// the largest, smallest and their spread with a one-cycle done pulse.
module maxmin_stream #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned COUNT  = 8,
  parameter bit          SIGNED = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             max,
  output logic [WIDTH-1:0]             min,
  output logic [WIDTH:0]               range,
  output logic                         done,
  output logic [$clog2(COUNT+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(COUNT + 1);

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] wmax, wmax_n, wmin, wmin_n;
  logic [WIDTH-1:0] max_n, min_n;
  logic [WIDTH:0]   range_n;
  logic             done_n, in_ready_n;
  logic             accept, last;

  // Strict greater-than in the configured number format
  function automatic logic gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    else        return a > b;
  endfunction

  // Widen by one bit so the difference can never wrap
  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
    if (SIGNED) return {x[WIDTH-1], x};
    else        return {1'b0, x};
  endfunction

  // Next-state, working registers and published results
  always_comb begin
    state_n    = state;
    count_n    = count;
    wmax_n     = wmax;
    wmin_n     = wmin;
    max_n      = max;
    min_n      = min;
    range_n    = range;
    done_n     = 1'b0;
    last       = 1'b0;
    accept     = in_valid && in_ready && !clr;

    case (state)
      LOAD: begin
        if (accept) begin
          wmax_n  = in;
          wmin_n  = in;
          count_n = CW'(1);
          if (COUNT == 1) last = 1'b1;
          else            state_n = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (gt(in, wmax)) wmax_n = in;
          if (gt(wmin, in)) wmin_n = in;
          count_n = count + CW'(1);
          if (count == CW'(COUNT - 1)) last = 1'b1;
        end
      end
      DONE:    state_n = LOAD;
      default: state_n = LOAD;
    endcase

    if (last) begin
      state_n = DONE;
      count_n = '0;
      max_n   = wmax_n;
      min_n   = wmin_n;
      range_n = ext(wmax_n) - ext(wmin_n);
      done_n  = 1'b1;
    end

    // Abort never touches the published results; accept is already gated
    if (clr) begin
      state_n = LOAD;
      count_n = '0;
    end

    in_ready_n = (state_n != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      count    <= '0;
      wmax     <= '0;
      wmin     <= '0;
      max      <= '0;
      min      <= '0;
      range    <= '0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      count    <= count_n;
      wmax     <= wmax_n;
      wmin     <= wmin_n;
      max      <= max_n;
      min      <= min_n;
      range    <= range_n;
      done     <= done_n;
      in_ready <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_maxmin_stream.sv
// Directed bench for maxmin_stream: signed and unsigned COUNT=4 instances
// share one stream; a COUNT=1 instance runs on its own inputs.
module tb_maxmin_stream;

  logic       clk;
  logic       rst, clr;
  logic       vld, v1;
  logic [7:0] din, d1;

  logic       s_rdy, s_done, u_rdy, u_done, o_rdy, o_done;
  logic [7:0] s_max, s_min, u_max, u_min, o_max, o_min;
  logic [8:0] s_range, u_range, o_range;
  logic [2:0] s_count, u_count;
  logic [0:0] o_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] samp   [4];
  logic [7:0] e_samp [4];
  logic [7:0] f_samp [6];
  int dones, lows;

  maxmin_stream #(.WIDTH(8), .COUNT(4), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(vld), .in(din),
    .in_ready(s_rdy), .max(s_max), .min(s_min), .range(s_range),
    .done(s_done), .count(s_count));

  maxmin_stream #(.WIDTH(8), .COUNT(4), .SIGNED(1'b0)) u_u (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(vld), .in(din),
    .in_ready(u_rdy), .max(u_max), .min(u_min), .range(u_range),
    .done(u_done), .count(u_count));

  maxmin_stream #(.WIDTH(8), .COUNT(1), .SIGNED(1'b1)) u_1 (
    .clk(clk), .rst(rst), .clr(1'b0), .in_valid(v1), .in(d1),
    .in_ready(o_rdy), .max(o_max), .min(o_min), .range(o_range),
    .done(o_done), .count(o_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    samp[0] = 8'h05; samp[1] = 8'hFD; samp[2] = 8'h07; samp[3] = 8'h00;
    e_samp[0] = 8'h01; e_samp[1] = 8'h02; e_samp[2] = 8'h03; e_samp[3] = 8'hFF;
    f_samp[0] = 8'h80; f_samp[1] = 8'h80; f_samp[2] = 8'h80;
    f_samp[3] = 8'h80; f_samp[4] = 8'h7F; f_samp[5] = 8'h00;

    rst = 1'b1; clr = 1'b0; vld = 1'b0; din = '0; v1 = 1'b0; d1 = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_done",  32'(s_done),  32'd0);
    check("rst_max",   32'(s_max),   32'd0);
    check("rst_min",   32'(s_min),   32'd0);
    check("rst_range", 32'(s_range), 32'd0);
    check("rst_count", 32'(s_count), 32'd0);
    check("rst_rdy",   32'(s_rdy),   32'd1);
    check("rst_rdy1",  32'(o_rdy),   32'd1);

    // Back-to-back frame 5, -3, 7, 0
    vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = samp[i];
      tick;
      if (i < 3) check("a_count", 32'(s_count), i + 1);
    end
    vld = 1'b0;
    check("a_done",   32'(s_done),  32'd1);
    check("a_max",    32'(s_max),   32'h07);
    check("a_min",    32'(s_min),   32'hFD);
    check("a_range",  32'(s_range), 32'd10);
    check("a_count0", 32'(s_count), 32'd0);
    check("a_rdy",    32'(s_rdy),   32'd0);
    check("a_umax",   32'(u_max),   32'hFD);
    check("a_umin",   32'(u_min),   32'h00);
    check("a_urange", 32'(u_range), 32'd253);
    check("a_udone",  32'(u_done),  32'd1);
    tick;
    check("a_pulse",  32'(s_done),  32'd0);
    check("a_rdy1",   32'(s_rdy),   32'd1);
    check("a_hold",   32'(s_max),   32'h07);

    // Same frame with idle gaps between samples
    for (int i = 0; i < 4; i++) begin
      vld = 1'b0;
      repeat (i % 2 + 1) begin
        tick;
        check("b_gap", 32'(s_count), i);
      end
      vld = 1'b1;
      din = samp[i];
      tick;
      vld = 1'b0;
      if (i < 3) check("b_count", 32'(s_count), i + 1);
    end
    check("b_done",  32'(s_done),  32'd1);
    check("b_max",   32'(s_max),   32'h07);
    check("b_min",   32'(s_min),   32'hFD);
    check("b_range", 32'(s_range), 32'd10);

    // Partial frame aborted by clr, then a fresh frame 1..4
    tick;
    vld = 1'b1;
    din = 8'h20; tick;
    din = 8'h30; tick;
    check("c_part", 32'(s_count), 32'd2);
    clr = 1'b1; din = 8'h7F; tick;
    clr = 1'b0;
    check("c_clr_count", 32'(s_count), 32'd0);
    check("c_clr_max",   32'(s_max),   32'h07);
    check("c_clr_umax",  32'(u_max),   32'hFD);
    check("c_clr_done",  32'(s_done),  32'd0);
    for (int i = 1; i <= 4; i++) begin
      din = 8'(i);
      tick;
      if (i < 4) begin
        check("c_held_max", 32'(s_max),  32'h07);
        check("c_held_min", 32'(s_min),  32'hFD);
        check("c_nodone",   32'(s_done), 32'd0);
      end
    end
    vld = 1'b0;
    check("c_done",  32'(s_done),  32'd1);
    check("c_max",   32'(s_max),   32'd4);
    check("c_min",   32'(s_min),   32'd1);
    check("c_range", 32'(s_range), 32'd3);
    check("c_umax",  32'(u_max),   32'd4);
    // clr during the publish cycle: result kept, back to an empty frame
    clr = 1'b1;
    tick;
    clr = 1'b0;
    check("c_dclr_rdy",   32'(s_rdy),   32'd1);
    check("c_dclr_count", 32'(s_count), 32'd0);
    check("c_dclr_max",   32'(s_max),   32'd4);

    // in_valid held for three frames; the sample offered during DONE is dropped
    dones = 0; lows = 0;
    vld = 1'b1;
    for (int j = 0; j < 15; j++) begin
      din = 8'(j);
      tick;
      if (!s_rdy) lows++;
      if (s_done) begin
        check("d_max", 32'(s_max), 5 * dones + 3);
        check("d_min", 32'(s_min), 5 * dones);
        dones++;
      end
    end
    vld = 1'b0;
    check("d_dones", dones, 3);
    check("d_lows",  lows,  3);

    // Reset mid-frame outranks in_valid, next four samples form a frame
    vld = 1'b1;
    din = 8'h50; tick;
    din = 8'h60; tick;
    rst = 1'b1; din = 8'h70; tick;
    rst = 1'b0;
    check("e_count", 32'(s_count), 32'd0);
    check("e_max",   32'(s_max),   32'd0);
    check("e_range", 32'(s_range), 32'd0);
    check("e_rdy",   32'(s_rdy),   32'd1);
    for (int i = 0; i < 4; i++) begin
      din = e_samp[i];
      tick;
    end
    vld = 1'b0;
    check("e_done",   32'(s_done),  32'd1);
    check("e_max2",   32'(s_max),   32'h03);
    check("e_min2",   32'(s_min),   32'hFF);
    check("e_range2", 32'(s_range), 32'd4);
    check("e_umax",   32'(u_max),   32'hFF);
    check("e_umin",   32'(u_min),   32'h01);
    check("e_urange", 32'(u_range), 32'd254);

    // COUNT=1: every accepted sample is its own frame
    for (int k = 0; k < 6; k++) begin
      v1 = 1'b1;
      d1 = f_samp[k];
      tick;
      v1 = 1'b0;
      check("f_done",  32'(o_done),  32'd1);
      check("f_max",   32'(o_max),   32'(f_samp[k]));
      check("f_min",   32'(o_min),   32'(f_samp[k]));
      check("f_range", 32'(o_range), 32'd0);
      tick;
      check("f_pulse", 32'(o_done),  32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
